// File: rtl/in_port_unit_pkg.sv
// in_port_unit_pkg: sizing defaults and width helpers shared by the input port front end.
package in_port_unit_pkg;
   localparam int unsigned INPORT_WIDTH       = 32;
   localparam int unsigned INPORT_DEPTH       = 4;
   localparam int unsigned INPORT_SYNC_STAGES = 2;
   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/in_port_unit_sync_edge_detect.sv
// sync_edge_detect: synchronises an asynchronous strobe into clk and emits a one-cycle rise pulse,
// plus a load strobe on the edge where the last synchroniser stage rises.
module sync_edge_detect #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_strobe,
   output logic o_load,
   output logic o_pulse
);
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_edge;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync <= '0;
         r_edge <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_strobe};
         r_edge <= r_sync[SYNC_STAGES-1];
      end
   end
   // data is latched alongside the last stage rising, so it is ready when the pulse pushes it
   assign o_load  = r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];
   assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_edge;
endmodule

// File: rtl/in_port_unit.sv
// in_port_unit: strobe-captured external words queued in a show-ahead FIFO for the InPortData bus.
// Define INPORT_IRQ_EN to add a registered irq output that is high while the FIFO holds data.
module in_port_unit
   import in_port_unit_pkg::*;
#(
   parameter int unsigned WIDTH       = INPORT_WIDTH,
   parameter int unsigned DEPTH       = INPORT_DEPTH,
   parameter int unsigned SYNC_STAGES = INPORT_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] ext_data,
   input  logic             ext_strobe,
   output logic             ext_ready,
   input  logic             in_rd,
   output logic [WIDTH-1:0] InPortData,
   output logic             in_empty,
   output logic             overflow,
   input  logic             clr_overflow
`ifdef INPORT_IRQ_EN
   ,
   output logic             irq
`endif
);
   localparam int unsigned PW = ptr_w(DEPTH);
   localparam int unsigned CW = cnt_w(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_data;
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_overflow;
   logic             w_load;
   logic             w_pulse;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset   (reset),
      .i_strobe(ext_strobe),
      .o_load  (w_load),
      .o_pulse (w_pulse)
   );

   assign w_full     = r_count == CW'(DEPTH);
   assign in_empty   = r_count == '0;
   assign ext_ready  = ~w_full;
   assign w_pop      = in_rd & ~in_empty;
   // a pop frees the slot in the same cycle, so a full FIFO still accepts the capture
   assign w_push     = w_pulse & (~w_full | w_pop);
   assign w_drop     = w_pulse & w_full & ~w_pop;
   assign InPortData = in_empty ? '0 : r_mem[r_rd_ptr];
   assign overflow   = r_overflow;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_data     <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_load) r_data <= ext_data;
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count    <= r_count + CW'(w_push) - CW'(w_pop);
         r_overflow <= w_drop ? 1'b1 : clr_overflow ? 1'b0 : r_overflow;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= r_data;
   end

`ifdef INPORT_IRQ_EN
   logic r_irq;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_irq <= 1'b0;
      else r_irq <= ~in_empty;
   end
   assign irq = r_irq;
`endif
endmodule
